// File: rtl/ram_fifo_pkg.sv
// Shared defaults for the RAM-backed FIFO controller.
package ram_fifo_pkg;
   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;

   typedef logic [ADDR_W_DEF-1:0] ptr_t;
endpackage

// File: rtl/ram_fifo_skid.sv
// Two-entry output buffer fed by RAM read data; entry 0 is the head presented downstream.
module ram_fifo_skid
   import ram_fifo_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        occ,
   output logic [DATA_W-1:0] head,
   output logic              valid
);

   logic [DATA_W-1:0] e0_p2, e1_p2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ   <= 2'd0;
         e0_p2 <= '0;
         e1_p2 <= '0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (occ == 2'd0) e0_p2 <= push_data;
               else             e1_p2 <= push_data;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               e0_p2 <= e1_p2;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               // shift and refill on the same edge; occupancy unchanged
               if (occ == 2'd1) begin
                  e0_p2 <= push_data;
               end else begin
                  e0_p2 <= e1_p2;
                  e1_p2 <= push_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign head  = e0_p2;
   assign valid = (occ != 2'd0);

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a simple dual-port synchronous-read RAM: write/read pointers,
// RAM occupancy, one-cycle read-in-flight flag and a 2-entry output buffer.
module ram_fifo_ctrl
   import ram_fifo_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [ADDR_W-1:0] ram_wradd,
   output logic [ADDR_W-1:0] ram_rdadd,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              empty
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W-1:0] wp_p0, rp_p0;
   logic [ADDR_W:0]   mem_cnt_p0;
   logic              inflight_p1;
   logic [1:0]        out_occ;
   logic              accept, m_pop, rd_issue;
   logic [2:0]        pend;

   // s_ready depends only on registered occupancy, never on m_ready
   assign full      = (mem_cnt_p0 == DEPTH);
   assign s_ready   = ~full & ~rst;
   assign accept    = s_valid & s_ready;
   assign ram_we    = accept;
   assign ram_wdata = s_data;
   assign ram_wradd = wp_p0;
   assign ram_rdadd = rp_p0;

   assign m_pop    = m_valid & m_ready;
   assign pend     = {1'b0, out_occ} + {2'b00, inflight_p1} - {2'b00, m_pop};
   assign rd_issue = (mem_cnt_p0 != '0) && (pend < 3'd2);
   assign empty    = (count == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_p0       <= '0;
         rp_p0       <= '0;
         mem_cnt_p0  <= '0;
         inflight_p1 <= 1'b0;
         count       <= '0;
      end else begin
         if (accept)   wp_p0 <= wp_p0 + ADDR_W'(1);
         if (rd_issue) rp_p0 <= rp_p0 + ADDR_W'(1);
         inflight_p1 <= rd_issue;
         unique case ({accept, rd_issue})
            2'b10:   mem_cnt_p0 <= mem_cnt_p0 + (ADDR_W+1)'(1);
            2'b01:   mem_cnt_p0 <= mem_cnt_p0 - (ADDR_W+1)'(1);
            default: ;
         endcase
         count <= count + {{ADDR_W{1'b0}}, accept} - {{ADDR_W{1'b0}}, m_pop};
      end
   end

   // ---- stage p1 -> p2: RAM read data captured into the output buffer
   ram_fifo_skid #(.DATA_W(DATA_W)) u_skid (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_p1),
      .push_data (ram_rdata),
      .pop       (m_pop),
      .occ       (out_occ),
      .head      (m_data),
      .valid     (m_valid)
   );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl at ADDR_W=16 and ADDR_W=3, each paired with a behavioural RAM.
module tb_ram_fifo_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       sel3    = 1'b0;
   logic       s_valid = 1'b0;
   logic [7:0] s_data  = 8'h00;
   logic       m_ready = 1'b0;

   logic        s_valid16, m_ready16, s_ready16, m_valid16, ram_we16, full16, empty16;
   logic [7:0]  m_data16, ram_wdata16, ram_rdata16;
   logic [15:0] ram_wradd16, ram_rdadd16;
   logic [16:0] count16;

   logic        s_valid3, m_ready3, s_ready3, m_valid3, ram_we3, full3, empty3;
   logic [7:0]  m_data3, ram_wdata3, ram_rdata3;
   logic [2:0]  ram_wradd3, ram_rdadd3;
   logic [3:0]  count3;

   assign s_valid16 = s_valid & ~sel3;
   assign m_ready16 = m_ready & ~sel3;
   assign s_valid3  = s_valid & sel3;
   assign m_ready3  = m_ready & sel3;

   ram_fifo_ctrl #(.ADDR_W(16), .DATA_W(8)) u16 (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid16), .s_ready(s_ready16),
      .m_data(m_data16), .m_valid(m_valid16), .m_ready(m_ready16),
      .ram_we(ram_we16), .ram_wdata(ram_wdata16), .ram_wradd(ram_wradd16),
      .ram_rdadd(ram_rdadd16), .ram_rdata(ram_rdata16),
      .count(count16), .full(full16), .empty(empty16)
   );

   ram_fifo_ctrl #(.ADDR_W(3), .DATA_W(8)) u3 (
      .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid3), .s_ready(s_ready3),
      .m_data(m_data3), .m_valid(m_valid3), .m_ready(m_ready3),
      .ram_we(ram_we3), .ram_wdata(ram_wdata3), .ram_wradd(ram_wradd3),
      .ram_rdadd(ram_rdadd3), .ram_rdata(ram_rdata3),
      .count(count3), .full(full3), .empty(empty3)
   );

   // behavioural synchronous-read RAMs
   logic [7:0] mem16 [0:65535];
   logic [7:0] mem3  [0:7];
   always @(posedge clk) begin
      if (ram_we16) mem16[ram_wradd16] <= ram_wdata16;
      ram_rdata16 <= mem16[ram_rdadd16];
      if (ram_we3) mem3[ram_wradd3] <= ram_wdata3;
      ram_rdata3 <= mem3[ram_rdadd3];
   end

   logic        cur_s_ready, cur_m_valid, cur_full, cur_empty, cur_ram_we;
   logic [7:0]  cur_m_data, cur_ram_wdata;
   logic [15:0] cur_ram_wradd, cur_ram_rdadd;
   logic [16:0] cur_count;
   assign cur_s_ready   = sel3 ? s_ready3   : s_ready16;
   assign cur_m_valid   = sel3 ? m_valid3   : m_valid16;
   assign cur_full      = sel3 ? full3      : full16;
   assign cur_empty     = sel3 ? empty3     : empty16;
   assign cur_ram_we    = sel3 ? ram_we3    : ram_we16;
   assign cur_m_data    = sel3 ? m_data3    : m_data16;
   assign cur_ram_wdata = sel3 ? ram_wdata3 : ram_wdata16;
   assign cur_ram_wradd = sel3 ? {13'd0, ram_wradd3} : ram_wradd16;
   assign cur_ram_rdadd = sel3 ? {13'd0, ram_rdadd3} : ram_rdadd16;
   assign cur_count     = sel3 ? {13'd0, count3}     : count16;

   int checks   = 0;
   int failures = 0;
   logic [7:0] model_q [$];
   int wr_total = 0;

   function automatic int depth();
      return sel3 ? 8 : 65536;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      m_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      wr_total = 0;
      #1;
   endtask

   // one clock: drive, judge transfers against the reference queue, advance, check occupancy
   task automatic cyc(input logic sv, input logic [7:0] sd, input logic mr,
                      output logic acc, output logic pop);
      s_valid = sv;
      s_data  = sd;
      m_ready = mr;
      #1;
      acc = s_valid & cur_s_ready;
      pop = cur_m_valid & m_ready;
      if (acc) begin
         chk("ram_we", 32'(cur_ram_we), 32'd1);
         chk("ram_wdata", 32'(cur_ram_wdata), 32'(sd));
         chk("ram_wradd", 32'(cur_ram_wradd), 32'(wr_total % depth()));
      end
      if (pop) begin
         if (model_q.size() == 0) chk("m_valid_while_model_empty", 32'(cur_m_valid), 32'd0);
         else begin
            chk("m_data_order", 32'(cur_m_data), 32'(model_q[0]));
            void'(model_q.pop_front());
         end
      end
      if (acc) begin
         model_q.push_back(sd);
         wr_total++;
      end
      @(posedge clk);
      @(negedge clk);
      chk("count", 32'(cur_count), 32'(model_q.size()));
      chk("empty", 32'(cur_empty), 32'(model_q.size() == 0));
   endtask

   logic acc, pop;
   int   pushed, popped, first_pop, last_pop, acc_cnt;

   initial begin
      // ---------- 1: reset mid-stream
      sel3 = 1'b0;
      do_reset();
      chk("rst_count", 32'(cur_count), 32'd0);
      chk("rst_empty", 32'(cur_empty), 32'd1);
      chk("rst_full", 32'(cur_full), 32'd0);
      chk("rst_m_valid", 32'(cur_m_valid), 32'd0);
      chk("rst_s_ready", 32'(cur_s_ready), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 8'(8'h10 + i), 1'b0, acc, pop);
         chk("t1_accept", 32'(acc), 32'd1);
      end
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_m_valid", 32'(m_valid16), 32'd0);
      chk("midrst_count", 32'(count16), 32'd0);
      chk("midrst_empty", 32'(empty16), 32'd1);
      chk("midrst_s_ready", 32'(s_ready16), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_q.delete();
      wr_total = 0;
      #1;
      chk("release_s_ready", 32'(s_ready16), 32'd1);

      // ---------- 2: single word latency
      cyc(1'b1, 8'hA3, 1'b1, acc, pop);
      chk("t2_accept", 32'(acc), 32'd1);
      chk("t2_mvalid_N", 32'(m_valid16), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, acc, pop);
      chk("t2_mvalid_N1", 32'(m_valid16), 32'd0);
      cyc(1'b0, 8'h00, 1'b1, acc, pop);
      chk("t2_mvalid_N2", 32'(m_valid16), 32'd1);
      chk("t2_mdata_N2", 32'(m_data16), 32'hA3);
      cyc(1'b0, 8'h00, 1'b1, acc, pop);
      chk("t2_popped", 32'(pop), 32'd1);
      chk("t2_mvalid_after", 32'(m_valid16), 32'd0);

      // ---------- 3: 100-word stream, no gaps
      do_reset();
      pushed = 0; popped = 0; first_pop = -1; last_pop = -1;
      for (int c = 0; c < 200 && popped < 100; c++) begin
         cyc(pushed < 100, 8'(pushed), 1'b1, acc, pop);
         if (acc) pushed++;
         if (pop) begin
            if (first_pop < 0) first_pop = c;
            last_pop = c;
            popped++;
         end
      end
      chk("t3_pushed", 32'(pushed), 32'd100);
      chk("t3_popped", 32'(popped), 32'd100);
      chk("t3_first_pop_cycle", 32'(first_pop), 32'd3);
      chk("t3_last_pop_cycle", 32'(last_pop), 32'd102);

      // ---------- 6: random backpressure
      do_reset();
      pushed = 0; popped = 0;
      for (int c = 0; c < 20000 && popped < 1000; c++) begin
         cyc((pushed < 1000) && ($urandom_range(0, 9) < 6), 8'($urandom),
             $urandom_range(0, 9) < 6, acc, pop);
         if (acc) pushed++;
         if (pop) popped++;
      end
      chk("t6_pushed", 32'(pushed), 32'd1000);
      chk("t6_popped", 32'(popped), 32'd1000);
      chk("t6_model_drained", 32'(model_q.size()), 32'd0);

      // ---------- 4: fill the 8-deep instance
      sel3 = 1'b1;
      do_reset();
      acc_cnt = 0;
      for (int c = 0; c < 20; c++) begin
         cyc(acc_cnt < 12, 8'(acc_cnt), 1'b0, acc, pop);
         if (acc) acc_cnt++;
      end
      chk("t4_accepted", 32'(acc_cnt), 32'd10);
      chk("t4_full", 32'(full3), 32'd1);
      chk("t4_s_ready", 32'(s_ready3), 32'd0);
      chk("t4_count", 32'(count3), 32'd10);
      for (int c = 0; c < 60 && (model_q.size() != 0 || m_valid3); c++)
         cyc(1'b0, 8'h00, 1'b1, acc, pop);
      chk("t4_drained_empty", 32'(empty3), 32'd1);
      chk("t4_drained_full", 32'(full3), 32'd0);
      chk("t4_rdadd", 32'(ram_rdadd3), 32'(wr_total % 8));

      // ---------- 5: pointer wrap on the 8-deep instance
      do_reset();
      pushed = 0; popped = 0;
      for (int c = 0; c < 100 && popped < 20; c++) begin
         cyc(pushed < 20, 8'(8'hC0 + pushed), 1'b1, acc, pop);
         if (acc) pushed++;
         if (pop) popped++;
      end
      chk("t5_popped", 32'(popped), 32'd20);
      chk("t5_wradd_final", 32'(ram_wradd3), 32'd4);
      chk("t5_rdadd_final", 32'(ram_rdadd3), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
